// File: rtl/comb_core_vector_sequencer.sv
// Sequencer that drives the 12-bit stimulus vector of the mapped combinational
// core, waits a programmable settle time, captures the 8-bit response and
// offers it on a valid/ready port. Each response is also folded into an 8-bit
// MISR. Vectors come from an internal 12-bit LFSR or from an external
// valid/ready stream.
//
// core_in_o  bit order (11..0): {n80,n78,n75,n72,n67,n57,n51,n35,n34,n22,n4,n2}
// core_out_i bit order (7..0) : {n77,n68,n65,n56,n48,n42,n9,n6}
module comb_core_vector_sequencer #(
    parameter int unsigned SETTLE    = 2,       // legal range 1..15
    parameter logic [11:0] LFSR_SEED = 12'h001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic [15:0] num_vectors_i,
    input  logic        ext_valid_i,
    output logic        ext_ready_o,
    input  logic [11:0] ext_data_i,
    output logic [11:0] core_in_o,
    input  logic [7:0]  core_out_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [7:0]  resp_data_o,
    output logic [7:0]  signature_o,
    output logic        busy_o,
    output logic        done_o
);

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [11:0] SEED      = (LFSR_SEED == 12'h000) ? 12'h001 : LFSR_SEED;
    localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        mode_q;
    logic [15:0] remaining_q;
    logic [3:0]  settle_q;
    logic [11:0] lfsr_q;
    logic [11:0] core_in_q;
    logic [7:0]  resp_data_q;
    logic [7:0]  sig_q;
    logic        resp_valid_q;
    logic        busy_q;
    logic        done_q;

    // Galois step, x^12 + x^6 + x^4 + x + 1
    function automatic logic [11:0] lfsr_step(input logic [11:0] v);
        return {v[10:0], 1'b0} ^ (v[11] ? 12'h053 : 12'h000);
    endfunction

    // MISR step, x^8 + x^4 + x^3 + x^2 + 1, with the response folded in
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
    endfunction

    // External vectors are only taken while applying in stream mode
    always_comb begin
        ext_ready_o = (state_q == S_APPLY) && mode_q;
    end

    // Run sequencing FSM with registered status/response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            remaining_q  <= '0;
            settle_q     <= '0;
            lfsr_q       <= SEED;
            core_in_q    <= '0;
            resp_data_q  <= '0;
            sig_q        <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q      <= mode_i;
                        remaining_q <= num_vectors_i;
                        sig_q       <= '0;
                        lfsr_q      <= SEED;
                        busy_q      <= 1'b1;
                        if (num_vectors_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_APPLY;
                        end
                    end
                end
                S_APPLY: begin
                    if (!mode_q) begin
                        core_in_q <= lfsr_q;
                        settle_q  <= SETTLE_M1;
                        state_q   <= S_WAIT;
                    end else if (ext_valid_i) begin
                        core_in_q <= ext_data_i;
                        settle_q  <= SETTLE_M1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - 4'd1;
                    end else begin
                        resp_data_q  <= core_out_i;
                        sig_q        <= misr_step(sig_q, core_out_i);
                        if (!mode_q) begin
                            lfsr_q <= lfsr_step(lfsr_q);
                        end
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - 16'd1;
                        end
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        if (remaining_q != '0) begin
                            state_q <= S_APPLY;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_in_o    = core_in_q;
    assign resp_data_o  = resp_data_q;
    assign resp_valid_o = resp_valid_q;
    assign signature_o  = sig_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_comb_core_vector_sequencer.sv
// Testbench for comb_core_vector_sequencer with a loopback core
// (core_out = core_in[7:0]) and an arithmetic reference model of the
// vector source, response stream, signature and run timing.
module tb_comb_core_vector_sequencer;

    localparam int unsigned SETTLE = 3;
    localparam int          SEED   = 'h800;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] num;
    logic        ext_valid;
    logic        ext_ready;
    logic [11:0] ext_data;
    logic [11:0] core_in;
    logic [7:0]  core_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic [7:0]  signature;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [11:0] ext_src[$];

    always #5 clk = ~clk;

    assign core_out = core_in[7:0];

    comb_core_vector_sequencer #(
        .SETTLE    (SETTLE),
        .LFSR_SEED (12'h800)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .mode_i        (mode),
        .num_vectors_i (num),
        .ext_valid_i   (ext_valid),
        .ext_ready_o   (ext_ready),
        .ext_data_i    (ext_data),
        .core_in_o     (core_in),
        .core_out_i    (core_out),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data),
        .signature_o   (signature),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // next LFSR value: multiply by x modulo x^12+x^6+x^4+x+1
    function automatic int lfsr_ref(input int v);
        int r;
        r = (v * 2) % 4096;
        if (v >= 2048) r = r ^ 'h053;
        return r;
    endfunction

    // next signature: multiply by x modulo x^8+x^4+x^3+x^2+1, add response
    function automatic int misr_ref(input int s, input int d);
        int r;
        r = (s * 2) % 256;
        if (s >= 128) r = r ^ 'h1D;
        return r ^ d;
    endfunction

    // advance to a point 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One run, starting from IDLE. Sample n means "just after edge n".
    task automatic run(input bit m, input int n, input int stall_pct,
                       input int bp_pct, input int bp_first, input bit stray);
        int exp_vec[$];
        int exp_sig[$];
        int k, t_load, t_done, t_event, prev_rise, ndone, bp_hold, budget, v, s, last;
        bit rv_prev, acc_prev, any_bp, pending, finished;
        logic [11:0] pend_data;

        k = 0; t_load = -1; t_done = -1; prev_rise = -1; ndone = 0;
        bp_hold = bp_first; rv_prev = 1'b0; acc_prev = 1'b0; any_bp = 1'b0;
        pending = 1'b0; finished = 1'b0; pend_data = '0;

        if (!m) begin
            v = SEED; s = 0;
            for (int i = 0; i < n; i++) begin
                exp_vec.push_back(v);
                s = misr_ref(s, v % 256);
                exp_sig.push_back(s);
                v = lfsr_ref(v);
            end
        end

        start = 1'b1; mode = m; num = 16'(n);
        resp_ready = 1'b0; ext_valid = 1'b0;
        t_event = cyc;
        if (n == 0) t_done = cyc + 1;
        else if (!m) t_load = cyc + 2;
        budget = 100 + n * 200;

        for (int c = 0; c < budget && !finished; c++) begin
            tick();
            // observe
            if (acc_prev) begin
                check("resume_rv_low", 32'(resp_valid), 0);
                check("resume_busy", 32'(busy), 1);
            end
            if (m && k < n && cyc == t_event + 1) check("ext_ready_apply", 32'(ext_ready), 1);
            if (!m) check("ext_ready_lfsr", 32'(ext_ready), 0);
            if (k < exp_vec.size() && cyc == t_load) check("core_in_load", 32'(core_in), exp_vec[k]);
            if (resp_valid) begin
                if (k >= n || k >= exp_vec.size()) begin
                    check("spurious_resp", 32'(resp_valid), 0);
                end else begin
                    if (!rv_prev) begin
                        check("settle_latency", cyc - t_load, SETTLE);
                        if (!m && !any_bp && prev_rise >= 0)
                            check("vector_period", cyc - prev_rise, SETTLE + 2);
                        prev_rise = cyc;
                    end
                    check("resp_data", 32'(resp_data), exp_vec[k] % 256);
                    check("signature", 32'(signature), exp_sig[k]);
                    check("core_in_held", 32'(core_in), exp_vec[k]);
                    check("ext_ready_in_resp", 32'(ext_ready), 0);
                end
            end
            if (t_done < 0 || cyc <= t_done) check("busy_run", 32'(busy), 1);
            if (done) begin
                ndone++;
                check("done_time", cyc, t_done);
            end
            if (t_done >= 0 && cyc == t_done + 1) begin
                check("busy_fall", 32'(busy), 0);
                check("done_low", 32'(done), 0);
                finished = 1'b1;
            end
            rv_prev = resp_valid;

            if (!finished) begin
                // stray control inputs, all of which must be ignored mid-run
                start = stray ? busy : 1'b0;
                mode  = 1'($urandom);
                num   = 16'($urandom);

                // response side
                if (resp_valid && bp_hold > 0) begin
                    resp_ready = 1'b0; bp_hold--; any_bp = 1'b1;
                end else if (bp_pct > 0 && $urandom_range(99) < bp_pct) begin
                    resp_ready = 1'b0;
                    if (resp_valid) any_bp = 1'b1;
                end else begin
                    resp_ready = 1'b1;
                end
                acc_prev = resp_valid && resp_ready;
                if (acc_prev && k < n) begin
                    k++; t_event = cyc;
                    if (k >= n) t_done = cyc + 1;
                    else if (!m) t_load = cyc + 2;
                end

                // external stream side
                if (!pending && $urandom_range(99) >= stall_pct) begin
                    pending = 1'b1;
                    if (ext_src.size() > 0) pend_data = ext_src.pop_front();
                    else pend_data = 12'($urandom);
                end
                ext_valid = pending;
                ext_data  = pend_data;
                if (m && ext_valid && ext_ready) begin
                    pending = 1'b0;
                    last = (exp_sig.size() > 0) ? exp_sig[exp_sig.size() - 1] : 0;
                    exp_vec.push_back(int'(pend_data));
                    exp_sig.push_back(misr_ref(last, int'(pend_data) % 256));
                    t_load = cyc + 1;
                end
            end
        end

        start = 1'b0; ext_valid = 1'b0; resp_ready = 1'b0;
        if (!finished) check("run_timeout", 0, 1);
        check("done_count", ndone, 1);
        check("resp_count", k, n);
        last = (exp_sig.size() > 0) ? exp_sig[exp_sig.size() - 1] : 0;
        check("final_signature", 32'(signature), last);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; num = '0;
        ext_valid = 1'b0; ext_data = '0; resp_ready = 1'b0;

        // reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_ext_ready", 32'(ext_ready), 0);
        check("rst_core_in", 32'(core_in), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_signature", 32'(signature), 0);
        rst = 1'b0;
        tick();

        // external stream, two directed vectors
        ext_src.push_back(12'h0A5);
        ext_src.push_back(12'h03C);
        run(1'b1, 2, 0, 0, 0, 1'b0);
        check("ext_sig_const", 32'(signature), 'h6B);
        check("ext_resp_const", 32'(resp_data), 'h3C);

        // LFSR, two vectors from seed 800
        run(1'b0, 2, 0, 0, 0, 1'b0);
        check("lfsr_sig_const", 32'(signature), 'h53);
        check("lfsr_core_in_const", 32'(core_in), 'h053);

        // LFSR throughput with resp_ready held high
        run(1'b0, 5, 0, 0, 0, 1'b0);

        // backpressure for 10 cycles on the first response
        run(1'b0, 3, 0, 0, 10, 1'b0);
        run(1'b1, 3, 0, 0, 10, 1'b0);

        // empty runs with start held while busy
        run(1'b0, 0, 0, 0, 0, 1'b1);
        run(1'b1, 0, 0, 0, 0, 1'b1);

        // randomized runs: stalls, backpressure, stray inputs
        for (int r = 0; r < 8; r++)
            run(1'($urandom), int'($urandom_range(1, 6)), 30, 30, 0, 1'b1);

        // reset during the settle wait of the second external vector
        tick();
        start = 1'b1; mode = 1'b1; num = 16'd3;
        ext_valid = 1'b1; ext_data = 12'h0A5; resp_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_busy", 32'(busy), 1);
        check("pre_reset_rv", 32'(resp_valid), 0);
        check("pre_reset_sig", 32'(signature), 'hA5);
        rst = 1'b1; ext_valid = 1'b0; resp_ready = 1'b0;
        tick();
        check("midrun_rst_busy", 32'(busy), 0);
        check("midrun_rst_core_in", 32'(core_in), 0);
        check("midrun_rst_sig", 32'(signature), 0);
        check("midrun_rst_rv", 32'(resp_valid), 0);
        rst = 1'b0;
        tick();

        // LFSR restarts from the seed after reset
        run(1'b0, 3, 0, 20, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
